// File: rtl/mipspkg.sv
`default_nettype none
// ============================================================================
// Module   : TYPES (package)
// Brief    : Shared MIPS-lite types: control word, data/register widths,
//            opcode class boundaries and the writeback FSM state encoding.
// Revision : 1.0
// ============================================================================
package TYPES;

    localparam int REGISTER_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    typedef logic [DATA_WIDTH-1:0] DATA;

    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic [3:0] aluOp;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic       regWrite;
        logic       wbMux;
    } Control;

    // Upper bound of each opcode class; classes are contiguous from 0x00.
    localparam logic [5:0] OP_ARITH_LAST = 6'h05;
    localparam logic [5:0] OP_LOGIC_LAST = 6'h0B;
    localparam logic [5:0] OP_MEM_LAST   = 6'h0D;
    localparam logic [5:0] OP_HALT       = 6'h11;

    typedef enum logic [1:0] {
        WB_RUN     = 2'd0,
        WB_DRAIN   = 2'd1,
        WB_HALTED  = 2'd2
    } wb_state_e;

    typedef enum logic [2:0] {
        CLS_ARITH  = 3'd0,
        CLS_LOGIC  = 3'd1,
        CLS_MEM    = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_NONE   = 3'd4
    } op_class_e;

    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e cls;
        if (op <= OP_ARITH_LAST)      cls = CLS_ARITH;
        else if (op <= OP_LOGIC_LAST) cls = CLS_LOGIC;
        else if (op <= OP_MEM_LAST)   cls = CLS_MEM;
        else if (op <= OP_HALT)       cls = CLS_BRANCH;
        else                          cls = CLS_NONE;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_writeback_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : wb_sat_counter
// Brief    : Up-counter that sticks at all-ones; synchronous clear.
// Revision : 1.0
// ============================================================================
module wb_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : mips_writeback_stage
// Brief    : WB stage: register-file write port, HALT drain and retirement
//            statistics. Optional class counters under WB_CLASS_STATS_EN.
// Revision : 1.0
// ============================================================================
module mips_writeback_stage
    import TYPES::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  Control                    mem_cntrl,
    input  logic [REGISTER_WIDTH-1:0] mem_rd,
    input  DATA                       mem_alu,
    input  DATA                       mem_load,
    input  logic [5:0]                mem_opcode,
    output Control                    wb_cntrl,
    output logic [REGISTER_WIDTH-1:0] wb_rd,
    output DATA                       wb_data,
    output logic                      wb_en_write,
    output logic                      halted,
    output logic [CNT_W-1:0]          retired,
    output logic [CNT_W-1:0]          arith_cnt,
    output logic [CNT_W-1:0]          logic_cnt,
    output logic [CNT_W-1:0]          mem_cnt,
    output logic [CNT_W-1:0]          branch_cnt
);

    localparam logic [2:0] DRAIN_LAST = 3'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

    wb_state_e  state;
    logic [2:0] drain_cnt;
    logic       xfer;
    logic       is_halt;

    assign mem_ready = (state == WB_RUN);
    assign xfer      = mem_valid && mem_ready;
    assign is_halt   = (mem_opcode == OP_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WB_RUN;
            drain_cnt   <= 3'd0;
            wb_cntrl    <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_en_write <= 1'b0;
            halted      <= 1'b0;
        end else begin
            // Bubbles and HALT only kill the write; rd/data hold their values.
            wb_cntrl.regWrite <= 1'b0;
            wb_en_write       <= 1'b0;
            if (xfer && !is_halt) begin
                wb_cntrl    <= mem_cntrl;
                wb_rd       <= mem_rd;
                wb_data     <= mem_cntrl.wbMux ? mem_alu : mem_load;
                wb_en_write <= mem_cntrl.regWrite;
            end

            case (state)
                WB_RUN: begin
                    if (xfer && is_halt) begin
                        if (DRAIN_CYCLES == 0) begin
                            state  <= WB_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state     <= WB_DRAIN;
                            drain_cnt <= 3'd0;
                        end
                    end
                end
                WB_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= WB_HALTED;
                        halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                WB_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= WB_RUN;
                end
            endcase
        end
    end

    wb_sat_counter #(.WIDTH(CNT_W)) u_retired (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (xfer),
        .count (retired)
    );

`ifdef WB_CLASS_STATS_EN
    op_class_e cls;
    assign cls = op_class(mem_opcode);

    wb_sat_counter #(.WIDTH(CNT_W)) u_arith (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(xfer && (cls == CLS_ARITH)),  .count(arith_cnt)
    );
    wb_sat_counter #(.WIDTH(CNT_W)) u_logic (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(xfer && (cls == CLS_LOGIC)),  .count(logic_cnt)
    );
    wb_sat_counter #(.WIDTH(CNT_W)) u_mem (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(xfer && (cls == CLS_MEM)),    .count(mem_cnt)
    );
    wb_sat_counter #(.WIDTH(CNT_W)) u_branch (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(xfer && (cls == CLS_BRANCH)), .count(branch_cnt)
    );
`else
    assign arith_cnt  = '0;
    assign logic_cnt  = '0;
    assign mem_cnt    = '0;
    assign branch_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/mips_writeback_stage.md
Name: mips_writeback_stage

Overview:
- Final (WB) stage of the MIPS-lite 5-stage pipeline.
- Registers the retiring instruction from the MEM stage.
- Selects the ALU result or load data, and drives the register-file write port of the decode stage (control struct, destination register, write data, write enable).
- Owns halt retirement: after a HALT retires, drains the pipeline and asserts a sticky halted flag. Keeps the retired-instruction count.

Parameters:
- DRAIN_CYCLES, 2, cycles between HALT retirement and halted assertion; range 0..7.
- CNT_W, 32, width of every statistics counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- mem_valid  in  1  MEM stage presents a retiring instruction
- mem_ready  out  1  WB accepts this cycle
- mem_cntrl  in  TYPES::Control  control of the instruction (regWrite, wbMux used)
- mem_rd  in  REGISTER_WIDTH  destination register
- mem_alu  in  DATA  ALU result
- mem_load  in  DATA  data-memory read data
- mem_opcode  in  6  opcode of the instruction
- wb_cntrl  out  TYPES::Control  to decode inputCntrl
- wb_rd  out  REGISTER_WIDTH  to decode inputRd
- wb_data  out  DATA  to decode data_write
- wb_en_write  out  1  to decode en_write; equals wb_cntrl.regWrite
- halted  out  1  sticky; machine stopped
- retired  out  CNT_W  instructions retired, HALT included
- arith_cnt, logic_cnt, mem_cnt, branch_cnt  out  CNT_W each  class counters (see Optional Feature)

Behaviour:
- Accept: a transfer occurs when mem_valid && mem_ready.
- mem_ready is combinational: 1 in RUN, 0 in DRAIN and HALTED. mem_* inputs are ignored when no transfer occurs.
- Latency: exactly 1 cycle. Outputs are registered and change only on posedge clk. They stay stable for the full cycle, so the decode stage's posedge write and negedge read both see consistent values.
- Accepted non-HALT instruction (opcode != 6'h11):
  - wb_cntrl <= mem_cntrl; wb_rd <= mem_rd.
  - wb_data <= mem_cntrl.wbMux ? mem_alu : mem_load.
  - wb_en_write <= mem_cntrl.regWrite.
- Accepted HALT: retires (counts) but wb_cntrl.regWrite <= 0 and wb_en_write <= 0. FSM RUN->DRAIN, drain counter <= 0.
- No transfer (bubble): wb_cntrl.regWrite <= 0 and wb_en_write <= 0. wb_rd and wb_data hold their previous values.
- Writes to register 0 are not suppressed (the register file is fully writable).
- FSM:
  - RUN: accept instructions.
  - DRAIN: count cycles; when count == DRAIN_CYCLES-1 go to HALTED. DRAIN_CYCLES = 0 skips DRAIN, so RUN goes straight to HALTED.
  - HALTED: halted = 1 (registered, asserted on entry). Exit only via rst.
- retired: +1 per accepted instruction; saturates at all-ones.
- Reset: asynchronous; all outputs and state clear immediately. FSM = RUN, counters = 0, wb_cntrl = '0, wb_rd = 0, wb_data = 0, wb_en_write = 0, halted = 0.
- Reset asserted mid-DRAIN or in HALTED returns to RUN. The first transfer is possible on the first posedge after rst deasserts.
- mem_valid during DRAIN/HALTED: not accepted, no write, no count.
- Opcode outside 0x00..0x11: retires like a non-HALT instruction; write per mem_cntrl (regWrite=0 from decode default).

Optional Feature:
- Macro: WB_CLASS_STATS_EN.
- Defined: on each accepted instruction, increment exactly one class counter, all saturating:
  - opcode 0x00-0x05 -> arith_cnt
  - 0x06-0x0B -> logic_cnt
  - 0x0C-0x0D -> mem_cnt
  - 0x0E-0x11 -> branch_cnt (HALT counts as branch)
  - other opcodes -> no class counter
- Undefined: the four ports remain and are tied to 0; no counter flops are synthesized.

Decomposition:
- Package TYPES (mipspkg.sv) holds the Control typedef, DATA, REGISTER_WIDTH, opcode constants (OP_HALT = 6'h11, class boundary opcodes), and wb_state_e {WB_RUN, WB_DRAIN, WB_HALTED}.
- One sub-module: wb_sat_counter (parameterised width, inc and clr inputs, saturating). Used for retired and the class counters.

Test Plan:
- ADD r3 with mem_alu=32'h0000_0010, wbMux=1, regWrite=1 -> next cycle wb_en_write=1, wb_rd=3, wb_data=32'h10; retired=1.
- LOAD r5, wbMux=0, mem_load=32'hDEAD_BEEF, mem_alu=32'h40 -> wb_data=32'hDEADBEEF, wb_rd=5.
- STORE (regWrite=0) followed by a bubble cycle -> wb_en_write=0 both cycles; wb_rd/wb_data hold; retired increments once.
- HALT then mem_valid=1 ADD, DRAIN_CYCLES=2 -> HALT gives no write; mem_ready=0 from the next cycle; ADD never written; halted=1 exactly 2 cycles after DRAIN entry; retired unchanged afterwards.
- rst pulsed asynchronously (between edges) during DRAIN -> outputs clear immediately; after release ADD r1 is accepted and written; halted=0.
- With WB_CLASS_STATS_EN: ADDI, ORI, LOAD, BEQ, HALT -> arith=1, logic=1, mem=1, branch=2, retired=5. Without the macro, all four class counters = 0.
